// File: rtl/sample_capture_if.sv
// Serial-link handshake between the capture block and the UART byte receiver/transmitter.
// master = serial side, slave = capture block.
interface sample_capture_if;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;

  modport master (
    output rx_data, new_rx_data, tx_busy,
    input  tx_data, new_tx_data
  );

  modport slave (
    input  rx_data, new_rx_data, tx_busy,
    output tx_data, new_tx_data
  );
endinterface

// File: rtl/sample_capture.sv
// Logic-analyzer style capture: 'r'+byte sets the sample divider, 'c' fills the buffer
// from synchronized probe pins, then the whole buffer is streamed out over the serial link.
//
// state     | meaning
// IDLE      | waiting for a command byte
// GET_RATE  | next received byte becomes the divider
// CAPTURE   | sampling pins into the buffer every DIV+1 clocks
// DUMP_READ | synchronous read of mem[addr] into tx_data
// DUMP_SEND | wait for transmitter idle, strobe one byte
// DUMP_GAP  | one spare cycle so tx_busy can rise
module sample_capture #(
  parameter int         DEPTH_LOG2  = 8,
  parameter logic [7:0] DEFAULT_DIV = 8'd0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     pins,
  output logic           busy,
  sample_capture_if.slave ser
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] ADDR_LAST = '1;
  localparam logic [7:0] CMD_RATE    = 8'h72;
  localparam logic [7:0] CMD_CAPTURE = 8'h63;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_RATE  = 3'd1,
    CAPTURE   = 3'd2,
    DUMP_READ = 3'd3,
    DUMP_SEND = 3'd4,
    DUMP_GAP  = 3'd5
  } state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] addr;
  logic [7:0]            div;
  logic [7:0]            div_cnt;
  logic [7:0]            pins_s1;
  logic [7:0]            pins_s2;
  logic [7:0]            tx_data_q;
  logic                  mem_we;

  logic [7:0] mem [DEPTH];

  assign mem_we = (state == CAPTURE) && (div_cnt == 8'd0);

  // Buffer is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= pins_s2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      div       <= DEFAULT_DIV;
      div_cnt   <= 8'd0;
      pins_s1   <= 8'd0;
      pins_s2   <= 8'd0;
      tx_data_q <= 8'd0;
    end else begin
      pins_s1 <= pins;
      pins_s2 <= pins_s1;
      case (state)
        IDLE: begin
          if (ser.new_rx_data) begin
            if (ser.rx_data == CMD_RATE) begin
              state <= GET_RATE;
            end else if (ser.rx_data == CMD_CAPTURE) begin
              state   <= CAPTURE;
              addr    <= '0;
              div_cnt <= 8'd0;
            end
          end
        end
        GET_RATE: begin
          if (ser.new_rx_data) begin
            div   <= ser.rx_data;
            state <= IDLE;
          end
        end
        CAPTURE: begin
          div_cnt <= (div_cnt == div) ? 8'd0 : div_cnt + 8'd1;
          if (div_cnt == 8'd0) begin
            addr <= addr + 1'b1;
            // Last slot written: addr wraps to 0, ready for the dump.
            if (addr == ADDR_LAST) state <= DUMP_READ;
          end
        end
        DUMP_READ: begin
          tx_data_q <= mem[addr];
          state     <= DUMP_SEND;
        end
        DUMP_SEND: begin
          if (!ser.tx_busy) begin
            addr  <= addr + 1'b1;
            state <= DUMP_GAP;
          end
        end
        DUMP_GAP: begin
          state <= (addr == '0) ? IDLE : DUMP_READ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobe follows tx_busy directly so a byte is never offered to a busy transmitter.
  assign ser.new_tx_data = (state == DUMP_SEND) && !ser.tx_busy;
  assign ser.tx_data     = tx_data_q;
  assign busy            = (state != IDLE) && (state != GET_RATE);

endmodule

// File: tb/tb_sample_capture.sv
// Randomized bench for sample_capture: every pin value is logged per clock and each dumped
// byte is predicted from that log using the capture timing rules.
module tb_sample_capture;

  localparam int NBYTES = 256;
  localparam int HIST   = 131072;

  logic       clk;
  logic       rst;
  logic [7:0] pins;
  logic       busy;

  sample_capture_if sif ();

  sample_capture #(.DEPTH_LOG2(8), .DEFAULT_DIV(8'd0)) dut (
    .clk  (clk),
    .rst  (rst),
    .pins (pins),
    .busy (busy),
    .ser  (sif.slave)
  );

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] hist [HIST];
  logic [7:0] got [$];
  int         viol     = 0;
  int         busy_len = 0;
  bit         counter_mode = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Log what the DUT sees on pins at every rising edge.
  always @(posedge clk) begin
    if (cyc < HIST) hist[cyc] = pins;
    cyc = cyc + 1;
  end

  initial begin
    forever begin
      @(negedge clk);
      pins = counter_mode ? pins + 8'd1 : 8'($urandom);
    end
  end

  // Serial-side monitor: collect strobed bytes and note strobes issued while busy.
  initial begin
    forever begin
      @(negedge clk);
      if (sif.new_tx_data === 1'b1) begin
        got.push_back(sif.tx_data);
        if (sif.tx_busy !== 1'b0) viol++;
      end
    end
  end

  // Transmitter model: raise tx_busy just after the edge that latched a byte.
  initial begin
    forever begin
      @(negedge clk);
      if (sif.new_tx_data === 1'b1 && busy_len > 0) begin
        @(posedge clk);
        #1 sif.tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 sif.tx_busy = 1'b0;
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, output int c);
    @(negedge clk);
    sif.rx_data     = b;
    sif.new_rx_data = 1'b1;
    c = cyc;
    @(negedge clk);
    sif.new_rx_data = 1'b0;
  endtask

  task automatic wait_bytes(input string name, input int n, input int budget);
    int t;
    t = 0;
    while (got.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (got.size() < n) begin
      failures++;
      $display("FAIL %s timeout: got %0d bytes, need %0d", name, got.size(), n);
    end
  endtask

  task automatic run_capture(input string name, input int div_exp, input bit inject);
    int c0, cd;
    logic [7:0] exp_b;
    got.delete();
    viol = 0;
    send_rx(8'h63, c0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_in_capture got=%b exp=1", name, busy);
    end
    if (inject) begin
      repeat (4) @(negedge clk);
      send_rx(8'h63, cd);
      send_rx(8'h72, cd);
      send_rx(8'h78, cd);
    end
    wait_bytes(name, NBYTES, NBYTES * (div_exp + 1) + NBYTES * (busy_len + 6) + 200);
    repeat (20) @(negedge clk);
    checks++;
    if (got.size() !== NBYTES) begin
      failures++;
      $display("FAIL %s strobe_count got=%0d exp=%0d", name, got.size(), NBYTES);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after_dump got=%b exp=0", name, busy);
    end
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL %s strobe_while_tx_busy got=%0d exp=0", name, viol);
    end
    // Sample k is the pin value seen one edge before the 'c' edge, plus k sample periods.
    for (int k = 0; k < NBYTES && k < got.size(); k++) begin
      exp_b = hist[c0 - 1 + k * (div_exp + 1)];
      checks++;
      if (got[k] !== exp_b) begin
        failures++;
        $display("FAIL %s byte[%0d] got=%02h exp=%02h", name, k, got[k], exp_b);
      end
    end
  endtask

  task automatic check_step(input string name, input logic [7:0] step);
    int bad;
    logic [7:0] d;
    bad = 0;
    for (int k = 0; k + 1 < got.size(); k++) begin
      d = got[k + 1] - got[k];
      if (d !== step) bad++;
    end
    checks++;
    if (bad !== 0 || got.size() !== NBYTES) begin
      failures++;
      $display("FAIL %s step: %0d diffs differ from %0d (bytes=%0d)", name, bad, step, got.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (sif.new_tx_data !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", sif.new_tx_data); end
    checks++;
    if (sif.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%02h exp=00", sif.tx_data); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_idle_junk();
    logic [7:0] junk [8];
    int c;
    junk[0] = 8'h68; junk[1] = 8'h00; junk[2] = 8'hFF;
    for (int i = 3; i < 8; i++) begin
      do junk[i] = 8'($urandom); while (junk[i] == 8'h63 || junk[i] == 8'h72);
    end
    got.delete();
    for (int i = 0; i < 8; i++) begin
      send_rx(junk[i], c);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_junk busy after %02h got=%b exp=0", junk[i], busy);
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (got.size() !== 0) begin
      failures++;
      $display("FAIL idle_junk strobes got=%0d exp=0", got.size());
    end
  endtask

  task automatic test_div0();
    counter_mode = 1'b1;
    busy_len = 0;
    run_capture("div0", 0, 1'b0);
    check_step("div0", 8'd1);
  endtask

  task automatic test_div3();
    int c;
    counter_mode = 1'b1;
    busy_len = 0;
    send_rx(8'h72, c);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    send_rx(8'h03, c);
    repeat (3) @(negedge clk);
    run_capture("div3", 3, 1'b0);
    check_step("div3", 8'd4);
  endtask

  task automatic test_backpressure();
    counter_mode = 1'b0;
    busy_len = 10;
    run_capture("backpressure", 3, 1'b0);
    busy_len = 0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_ignore_cmds();
    counter_mode = 1'b0;
    busy_len = 0;
    run_capture("ignore_cmds", 3, 1'b1);
    run_capture("div_retained", 3, 1'b0);
  endtask

  task automatic test_reset_mid_dump();
    int c;
    counter_mode = 1'b0;
    busy_len = 0;
    got.delete();
    send_rx(8'h63, c);
    wait_bytes("mid_dump", 100, NBYTES * 4 + 100 * 6 + 200);
    #3 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_dump_busy got=%b exp=0", busy); end
    checks++;
    if (sif.new_tx_data !== 1'b0) begin failures++; $display("FAIL mid_dump_strobe got=%b exp=0", sif.new_tx_data); end
    checks++;
    if (sif.tx_data !== 8'h00) begin failures++; $display("FAIL mid_dump_tx_data got=%02h exp=00", sif.tx_data); end
    repeat (5) @(negedge clk);
    checks++;
    if (got.size() !== 100) begin
      failures++;
      $display("FAIL mid_dump_no_more_strobes got=%0d exp=100", got.size());
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    run_capture("after_reset", 0, 1'b0);
  endtask

  initial begin
    rst             = 1'b0;
    pins            = 8'd0;
    sif.rx_data     = 8'd0;
    sif.new_rx_data = 1'b0;
    sif.tx_busy     = 1'b0;
    test_reset();
    test_idle_junk();
    test_div0();
    test_div3();
    test_backpressure();
    test_ignore_cmds();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_capture.md
SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of capture depth; the buffer holds 2^DEPTH_LOG2 samples.
REQ-002 Parameter DEFAULT_DIV, default 0, reset value of the sample-rate divider; one sample is taken every DIV+1 clocks.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 pins  input  8  raw probe inputs, asynchronous to clk.
REQ-006 rx_data  input  8  received command byte from the serial receiver.
REQ-007 new_rx_data  input  1  one-cycle strobe; rx_data is valid this cycle.
REQ-008 tx_data  output  8  byte offered to the serial transmitter.
REQ-009 new_tx_data  output  1  one-cycle strobe; transmitter latches tx_data this cycle.
REQ-010 tx_busy  input  1  transmitter busy; no strobe may be issued while high.
REQ-011 busy  output  1  high in any state other than IDLE and GET_RATE.

Function
REQ-012 Pins shall pass through a two-flop synchronizer; all samples are taken from the second flop (2-cycle input latency).
REQ-013 States: IDLE, GET_RATE, CAPTURE, DUMP_READ, DUMP_SEND, DUMP_GAP.
REQ-014 IDLE: new_rx_data with rx_data=0x72 ('r') -> GET_RATE; rx_data=0x63 ('c') -> CAPTURE with addr=0 and divider counter=0; all other bytes ignored.
REQ-015 GET_RATE: next new_rx_data loads rx_data into the 8-bit DIV register, then -> IDLE; no timeout.
REQ-016 CAPTURE: divider counter counts 0..DIV; when counter=0, mem[addr] <= synchronized pins and addr increments; the first sample is written in the first CAPTURE cycle.
REQ-017 CAPTURE: the write to address 2^DEPTH_LOG2-1 ends capture; next state DUMP_READ with addr wrapped to 0; no sample is overwritten.
REQ-018 DUMP_READ: issue synchronous read of mem[addr]; data is registered into tx_data one cycle later; -> DUMP_SEND.
REQ-019 DUMP_SEND: while tx_busy=1, hold; when tx_busy=0, assert new_tx_data for exactly one cycle with stable tx_data, increment addr, -> DUMP_GAP.
REQ-020 DUMP_GAP: one idle cycle so tx_busy may rise; then -> DUMP_READ, or -> IDLE if addr wrapped to 0 (all 2^DEPTH_LOG2 bytes sent).
REQ-021 Bytes are sent in capture order, address 0 first; exactly 2^DEPTH_LOG2 strobes per capture.
REQ-022 new_rx_data during CAPTURE or any DUMP state shall be ignored (not queued).
REQ-023 tx_data shall hold its last value outside DUMP_SEND; new_tx_data is 0 in every state except DUMP_SEND.
REQ-024 Address and divider counters wrap modulo their widths; DIV=255 gives one sample per 256 clocks.
REQ-025 Unused state encodings shall return to IDLE next cycle.

Reset
REQ-026 rst=0 asynchronously forces: state IDLE, addr 0, divider counter 0, DIV=DEFAULT_DIV, tx_data 0x00, new_tx_data 0, busy 0, synchronizer flops 0.
REQ-027 Memory contents are not reset; a reset mid-capture or mid-dump aborts with no further strobes, and the next 'c' starts a fresh capture at address 0.

Verification
REQ-028 Reset then 'c' with DIV=0, pins driving an 8-bit counter incrementing every clock -> 256 strobes, consecutive bytes differing by 1.
REQ-029 'r' then 0x03, then 'c' with same counter stimulus -> consecutive dumped bytes differ by 4.
REQ-030 tx_busy held high 10 cycles after each strobe -> no strobe while tx_busy=1, tx_data stable during each strobe, no byte lost or duplicated.
REQ-031 Send 'c','r','x' during CAPTURE -> ignored; DIV unchanged; exactly 256 strobes; busy falls after last strobe.
REQ-032 Assert rst=0 after the 100th strobe -> outputs reach reset values without a clock edge; subsequent 'c' produces a full 256-byte dump starting from address 0.
REQ-033 Bytes other than 'c'/'r' in IDLE (e.g. 'h', 0x00, 0xFF) -> no state change, busy stays 0, no strobe.
